// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   tx_state_e         : serializer FSM state encoding
//   PARITY_MODE_EVEN/ODD : value XORed onto the data parity to form the parity bit
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_hold_reg.sv
// Single-entry holding register in front of the serializer.
//   clk_i, rst_i : clock, async active-high reset
//   load_i       : write strobe, honoured only while empty
//   clear_i      : serializer has taken the held word
//   data_i       : word to hold
//   data_o       : held word
//   valid_o      : register holds a word not yet taken
module uart_tx_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o
);

   logic [DATA_W-1:0] data_q;
   logic              valid_q;

   // clear_i only fires while valid_q=1 and a load only lands while
   // valid_q=0, so the two never compete for the same edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i && !valid_q) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: holding register + frame FSM, LSB first,
// optional parity, one or two stop bits. All bit timing from baud_tick_i.
//   clk_i, rst_i : clock, async active-high reset
//   baud_tick_i  : one-cycle strobe per bit period
//   load_i       : write strobe, accepted when ready_o=1
//   data_i       : word to send
//   ready_o      : holding register empty
//   tx_o         : registered serial line, idle high
//   busy_o       : frame in progress
//   done_o       : one-cycle pulse, registered off the final stop-bit tick
//
// state     | meaning
// ST_IDLE   | line high, waiting for a tick with a held word
// ST_START  | start bit (0) on the line
// ST_DATA   | data bits, bit_cnt_q = bits still to follow the current one
// ST_PARITY | parity bit on the line
// ST_STOP   | stop bit(s), stop_cnt_q = stop periods still to follow
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              baud_tick_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int   CNT_W   = $clog2(DATA_W + 1);
   localparam logic PAR_INV = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
   localparam logic STOP_LD = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   tx_state_e         state_q;
   logic              tx_q;
   logic              done_q;
   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic              stop_cnt_q;
   logic              parity_q;

   logic [DATA_W-1:0] hold_data;
   logic              hold_valid;
   logic              xfer;

   // Word leaves the holding register on an IDLE tick or the final stop tick.
   assign xfer = baud_tick_i && hold_valid &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && !stop_cnt_q));

   uart_tx_hold_reg #(.DATA_W(DATA_W)) u_hold (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (load_i),
      .clear_i (xfer),
      .data_i  (data_i),
      .data_o  (hold_data),
      .valid_o (hold_valid)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (baud_tick_i) begin
            case (state_q)
               ST_IDLE: begin
                  if (hold_valid) begin
                     state_q  <= ST_START;
                     tx_q     <= 1'b0;
                     shift_q  <= hold_data;
                     parity_q <= (^hold_data) ^ PAR_INV;
                  end
               end
               ST_START: begin
                  state_q   <= ST_DATA;
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= CNT_W'(DATA_W - 1);
               end
               ST_DATA: begin
                  if (bit_cnt_q != '0) begin
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                  end else if (PARITY_EN != 0) begin
                     state_q <= ST_PARITY;
                     tx_q    <= parity_q;
                  end else begin
                     state_q    <= ST_STOP;
                     tx_q       <= 1'b1;
                     stop_cnt_q <= STOP_LD;
                  end
               end
               ST_PARITY: begin
                  state_q    <= ST_STOP;
                  tx_q       <= 1'b1;
                  stop_cnt_q <= STOP_LD;
               end
               ST_STOP: begin
                  if (stop_cnt_q) begin
                     stop_cnt_q <= 1'b0;
                  end else begin
                     done_q <= 1'b1;
                     // Back-to-back: next start bit follows the last stop bit directly.
                     if (hold_valid) begin
                        state_q  <= ST_START;
                        tx_q     <= 1'b0;
                        shift_q  <= hold_data;
                        parity_q <= (^hold_data) ^ PAR_INV;
                     end else begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  tx_q    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign ready_o = !hold_valid;
   assign tx_o    = tx_q;
   assign busy_o  = (state_q != ST_IDLE);
   assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       baud_tick_i;
   logic       load_i;
   logic [7:0] data_i;
   wire  [3:0] tx_v, rdy_v, busy_v, done_v;

   always #5 clk_i = ~clk_i;

   // 0: 8N1   1: 8E1   2: 8O1   3: 5N2
   uart_tx_serializer #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
      .clk_i(clk_i), .rst_i(rst_i), .baud_tick_i(baud_tick_i), .load_i(load_i), .data_i(data_i),
      .ready_o(rdy_v[0]), .tx_o(tx_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]));
   uart_tx_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
      .clk_i(clk_i), .rst_i(rst_i), .baud_tick_i(baud_tick_i), .load_i(load_i), .data_i(data_i),
      .ready_o(rdy_v[1]), .tx_o(tx_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]));
   uart_tx_serializer #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
      .clk_i(clk_i), .rst_i(rst_i), .baud_tick_i(baud_tick_i), .load_i(load_i), .data_i(data_i),
      .ready_o(rdy_v[2]), .tx_o(tx_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]));
   uart_tx_serializer #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
      .clk_i(clk_i), .rst_i(rst_i), .baud_tick_i(baud_tick_i), .load_i(load_i), .data_i(data_i[4:0]),
      .ready_o(rdy_v[3]), .tx_o(tx_v[3]), .busy_o(busy_v[3]), .done_o(done_v[3]));

   int cfg_w[4]    = '{8, 8, 8, 5};
   int cfg_pen[4]  = '{0, 1, 1, 0};
   int cfg_podd[4] = '{0, 0, 1, 0};
   int cfg_stop[4] = '{1, 1, 1, 2};

   // Reference model: each frame is a list of line levels, one per bit period.
   logic       m_hold[4];
   logic [7:0] m_hbyte[4];
   logic       m_done[4];
   logic       fb[4][16];
   int         flen[4];
   int         fpos[4];

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [3:0] cap[16];
   int         ncap;
   int         done_cnt[4];

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_hold[i] = 1'b0; m_hbyte[i] = '0; m_done[i] = 1'b0;
         flen[i] = 0; fpos[i] = 0; done_cnt[i] = 0;
      end
   endtask

   task automatic build_frame(input int i, input logic [7:0] b);
      int   n;
      logic p;
      fb[i][0] = 1'b0;
      n = 1;
      p = 1'b0;
      for (int k = 0; k < cfg_w[i]; k++) begin
         fb[i][n] = b[k];
         p ^= b[k];
         n++;
      end
      if (cfg_pen[i] != 0) begin
         fb[i][n] = p ^ (cfg_podd[i] != 0);
         n++;
      end
      for (int s = 0; s < cfg_stop[i]; s++) begin
         fb[i][n] = 1'b1;
         n++;
      end
      flen[i] = n;
      fpos[i] = 0;
   endtask

   task automatic model_step(input logic ld, input logic [7:0] d, input logic tk);
      logic old_hold;
      for (int i = 0; i < 4; i++) begin
         old_hold  = m_hold[i];
         m_done[i] = 1'b0;
         if (tk) begin
            if (fpos[i] < flen[i]) begin
               fpos[i]++;
               if (fpos[i] == flen[i]) begin
                  m_done[i] = 1'b1;
                  flen[i] = 0; fpos[i] = 0;
                  if (old_hold) begin
                     build_frame(i, m_hbyte[i]);
                     m_hold[i] = 1'b0;
                  end
               end
            end else if (old_hold) begin
               build_frame(i, m_hbyte[i]);
               m_hold[i] = 1'b0;
            end
         end
         if (ld && !old_hold) begin
            m_hold[i]  = 1'b1;
            m_hbyte[i] = d;
         end
      end
   endtask

   task automatic check_all();
      int act;
      for (int i = 0; i < 4; i++) begin
         act = (fpos[i] < flen[i]) ? 1 : 0;
         check($sformatf("tx%0d", i),    int'(tx_v[i]),   act ? int'(fb[i][fpos[i]]) : 1);
         check($sformatf("busy%0d", i),  int'(busy_v[i]), act);
         check($sformatf("ready%0d", i), int'(rdy_v[i]),  m_hold[i] ? 0 : 1);
         check($sformatf("done%0d", i),  int'(done_v[i]), int'(m_done[i]));
         if (done_v[i]) done_cnt[i]++;
      end
   endtask

   // Called at a negedge; applies inputs for one cycle and checks after it.
   task automatic step(input logic ld, input logic [7:0] d, input logic tk);
      load_i = ld; data_i = d; baud_tick_i = tk;
      @(posedge clk_i);
      model_step(ld, d, tk);
      @(negedge clk_i);
      load_i = 1'b0; baud_tick_i = 1'b0;
      check_all();
      if (tk && ncap < 16) begin
         cap[ncap] = tx_v;
         ncap++;
      end
   endtask

   task automatic tick_run(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 8'h00, 1'b0);
         step(1'b0, 8'h00, 1'b1);
      end
   endtask

   int exp_a[10] = '{0,1,0,1,0,0,1,0,1,1};
   int exp_b[11] = '{0,1,0,1,0,0,1,0,1,0,1};
   int exp_c[11] = '{0,1,0,1,0,0,1,0,1,1,1};
   int exp_d[8]  = '{0,1,1,1,1,1,1,1};

   initial begin
      rst_i = 1'b1; load_i = 1'b0; data_i = '0; baud_tick_i = 1'b0;
      model_reset();
      ncap = 0;
      repeat (2) @(negedge clk_i);
      check_all();
      rst_i = 1'b0;

      // 0xA5 on all configurations
      step(1'b1, 8'hA5, 1'b0);
      ncap = 0;
      tick_run(14);
      for (int k = 0; k < 10; k++) check($sformatf("a5_8n1_bit%0d", k), int'(cap[k][0]), exp_a[k]);
      for (int k = 0; k < 11; k++) check($sformatf("a5_8e1_bit%0d", k), int'(cap[k][1]), exp_b[k]);
      for (int k = 0; k < 11; k++) check($sformatf("a5_8o1_bit%0d", k), int'(cap[k][2]), exp_c[k]);
      check("a5_done_8n1", done_cnt[0], 1);

      // 0x1F on 5N2
      step(1'b1, 8'h1F, 1'b0);
      ncap = 0;
      tick_run(12);
      for (int k = 0; k < 8; k++) check($sformatf("1f_5n2_bit%0d", k), int'(cap[k][3]), exp_d[k]);
      check("1f_done_5n2", done_cnt[3], 2);

      // back-to-back, third load dropped while hold is full
      for (int i = 0; i < 4; i++) done_cnt[i] = 0;
      step(1'b1, 8'h11, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      tick_run(30);
      check("b2b_frames_8n1", done_cnt[0], 2);
      check("b2b_frames_5n2", done_cnt[3], 2);

      // reset during data bit 3 of 0x5A
      for (int i = 0; i < 4; i++) done_cnt[i] = 0;
      step(1'b1, 8'h5A, 1'b0);
      tick_run(5);
      rst_i = 1'b1;
      #1;
      model_reset();
      check("rst_tx",    int'(tx_v),   4'hF);
      check("rst_ready", int'(rdy_v),  4'hF);
      check("rst_busy",  int'(busy_v), 0);
      check("rst_done",  int'(done_v), 0);
      @(negedge clk_i);
      check_all();
      rst_i = 1'b0;
      step(1'b1, 8'h3C, 1'b0);
      tick_run(14);
      check("post_rst_frames_8n1", done_cnt[0], 1);

      // random traffic with varying tick density
      for (int n = 0; n < 3000; n++) begin
         logic ld, tk;
         ld = ($urandom_range(0, 3) == 0);
         if (n < 1000) tk = ($urandom_range(0, 2) == 0);
         else if (n < 2000) tk = 1'b1;
         else tk = ($urandom_range(0, 7) == 0);
         step(ld, 8'($urandom), tk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 1 selects odd parity, 0 selects even parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, legal 1..2.
REQ-005 The block SHALL have one clock, clk_i; reset SHALL be asynchronous and active-high, named rst_i.
REQ-006 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 baud_tick_i  input  1  one-cycle strobe marking each bit-period boundary.
REQ-009 load_i  input  1  write strobe from the TX FIFO/FSM.
REQ-010 data_i  input  DATA_W  byte to transmit, sampled when load_i=1 and ready_o=1.
REQ-011 ready_o  output  1  holding register empty; a load is accepted this cycle.
REQ-012 tx_o  output  1  serial line, idle high, registered.
REQ-013 busy_o  output  1  frame in progress (state not IDLE).
REQ-014 done_o  output  1  one-cycle pulse on the last stop-bit tick of each frame.

Function
REQ-015 Holding register: load_i=1 with ready_o=1 SHALL capture data_i and set hold_valid at the clock edge; ready_o = !hold_valid.
REQ-016 load_i while ready_o=0 SHALL be ignored; held data SHALL NOT change.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; transitions SHALL occur only on cycles with baud_tick_i=1.
REQ-018 IDLE + tick + hold_valid: move hold data to shifter, clear hold_valid, enter START, tx_o=0 from next cycle.
REQ-019 IDLE + tick + !hold_valid: remain IDLE, tx_o=1.
REQ-020 START + tick: enter DATA, tx_o=data bit 0 (LSB first).
REQ-021 DATA: each tick shifts the next bit; after bit DATA_W-1 has occupied one period, the next tick enters PARITY if PARITY_EN else STOP.
REQ-022 Parity bit SHALL be XOR of the DATA_W data bits, inverted when PARITY_ODD=1.
REQ-023 STOP: tx_o=1 for STOP_BITS bit periods; on the final STOP tick assert done_o and, if hold_valid, perform REQ-018 directly (back-to-back, no idle period), else enter IDLE.
REQ-024 Load and transfer on the same edge are impossible by construction (ready_o=0); ready_o SHALL rise the cycle after a transfer.
REQ-025 A load arriving on the same edge as a final STOP tick with ready_o=1 SHALL be captured but transmitted only on the next frame opportunity.
REQ-026 baud_tick_i during a cycle with no state change required SHALL have no side effect; absent ticks SHALL freeze all FSM and bit-counter state.
REQ-027 Bit counter width SHALL be $clog2(DATA_W+1); no wrap beyond DATA_W.

Reset
REQ-028 rst_i=1 SHALL immediately force: state IDLE, tx_o=1, hold_valid=0, ready_o=1, busy_o=0, done_o=0, shifter and counters 0.
REQ-029 Reset mid-frame SHALL abort the frame; no done_o pulse; the first post-reset frame starts from IDLE.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and parity-mode constants.
REQ-031 Holding register SHALL be the sub-module uart_tx_hold_reg (parametrised DATA_W enable register plus valid flag); FSM, shifter and parity inline.

Verification
REQ-032 DATA_W=8, no parity, 1 stop, load 0xA5 -> tx_o per tick: 0,1,0,1,0,0,1,0,1,1; done_o once; busy_o low after.
REQ-033 PARITY_EN=1, PARITY_ODD=0, load 0xA5 -> parity bit 0; PARITY_ODD=1 -> parity bit 1.
REQ-034 Load 0x11 then 0x22 while busy -> second load accepted into hold, frames back-to-back, stop of first immediately followed by start of second.
REQ-035 Third load while hold full and frame active -> ignored; only two frames appear on tx_o.
REQ-036 rst_i asserted at data bit 3 of 0x5A -> tx_o=1 same cycle, ready_o=1, no done_o; subsequent load 0x3C transmits correctly.
REQ-037 STOP_BITS=2, DATA_W=5, load 0x1F -> 0,1,1,1,1,1,1,1 then done_o.
